axi_read_burst_collector: RTL and testbench
===========================================

Name: axi_read_burst_collector

Overview:
- Downstream consumer of the AXI read channel pair (master/slave read bridges).
- Snoops the AR handshake to learn each burst's expected length, then accepts R beats by driving axi_rready.
- Buffers accepted beats in a small FIFO and presents them to the local consumer over a valid/ready interface.
- Checks the beat count against arlen and flags RLAST mismatches.

Parameters:
- DW, 64, R data width.
- DEPTH, 4, FIFO entries (power of 2, >=2).
- LW, 8, arlen width.

Ports:
- clk  in  1  global clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- axi_arvalid  in  1  AR valid (snooped).
- axi_arready  in  1  AR ready (snooped).
- axi_arlen  in  LW  burst length minus 1 (snooped).
- axi_rdata  in  DW  read data.
- axi_rlast  in  1  last beat of burst.
- axi_rvalid  in  1  read data valid.
- axi_rready  out  1  collector ready for R beat.
- out_data  out  DW  FIFO head data.
- out_last  out  1  FIFO head is final beat of burst.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head.
- err_clr  in  1  clears sticky error flags.
- busy  out  1  burst in progress (state RECV).
- len_err  out  1  sticky beat-count/RLAST mismatch.
- ar_ovf  out  1  sticky: AR handshake seen while busy.
- level  out  clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (resetn=0, async): state IDLE, FIFO emptied, beat counter 0, expected length 0. All outputs 0: axi_rready, out_valid, out_data, out_last, busy, len_err, ar_ovf, level.
- Reset mid-burst discards buffered beats and tracking state. No partial output after release.
- AR handshake = axi_arvalid & axi_arready on a clock edge.
- State machine:
  - IDLE: axi_rready=0; R beats are never accepted. On AR handshake, capture exp = axi_arlen+1 (LW+1 bits; arlen=255 gives 256), clear the beat counter, go to RECV.
  - RECV: axi_rready = !full (combinational from FIFO level). An R handshake (axi_rvalid & axi_rready) pushes {last_eff, axi_rdata}, where last_eff = axi_rlast | (cnt+1==exp), and increments cnt. When last_eff=1, return to IDLE on the same edge.
- Length check on the final beat:
  - axi_rlast=1 and cnt+1!=exp (early RLAST) sets len_err.
  - cnt+1==exp and axi_rlast=0 (missing RLAST) sets len_err.
  - In both cases the burst is terminated and out_last=1 on that beat.
- AR handshake while in RECV: descriptor is dropped and ar_ovf is set. An AR handshake on the same edge RECV returns to IDLE is also dropped and also sets ar_ovf.
- Sticky flags: err_clr clears len_err and ar_ovf. A set event on the same cycle as err_clr wins.
- FIFO: DEPTH entries, width DW+1, first-word fall-through.
  - out_valid = !empty; out_data/out_last are driven from the head entry, and are 0 when empty.
  - Pop on out_valid & out_ready.
  - Push and pop on the same edge are legal whenever not full; level is unchanged in that case.
  - Push is never attempted when full, since axi_rready=0.
  - Pointers wrap modulo DEPTH; full/empty are derived from level.
- Latency: a beat accepted at edge N is visible on out_data after edge N (same cycle as level increment). No combinational path from axi_rvalid to out_valid.
- axi_rready does not depend on axi_rvalid (no AXI handshake loop).

Test Plan:
- Normal burst: AR arlen=3, then 4 R beats with rdata=0x11..0x44, rlast on beat 4, out_ready=1 -> 4 outputs in order, out_last only on 0x44; len_err=0; busy drops after beat 4.
- Backpressure: DEPTH=4, arlen=7, out_ready=0 -> axi_rready falls after 4 beats and level=4. Raise out_ready -> remaining 4 beats flow, all 8 delivered in order, no loss or duplication.
- Early RLAST: arlen=3, rlast on beat 2 -> len_err=1, out_last on beat 2, state IDLE. err_clr pulse -> len_err=0.
- Missing RLAST and max length: arlen=255, 256 beats with rlast=0 -> len_err=1, out_last on beat 256, counter does not wrap to 0 prematurely.
- Overlap / stray: AR handshake during RECV -> ar_ovf=1, current burst completes normally. rvalid=1 in IDLE -> axi_rready stays 0, nothing pushed.
- Reset mid-burst: resetn low after 2 of 4 beats -> all outputs 0 immediately (asynchronously). After release, a new arlen=0 burst yields a single beat with out_last=1.

Source files
------------

// File: rtl/axi_read_burst_collector.sv
// AXI read-burst collector: snoops AR for burst length, accepts R beats into a
// first-word-fall-through FIFO, and flags beat-count / RLAST mismatches.
module axi_read_burst_collector #(
    parameter int DW    = 64,
    parameter int DEPTH = 4,
    parameter int LW    = 8
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       axi_arvalid,
    input  logic                       axi_arready,
    input  logic [LW-1:0]              axi_arlen,
    input  logic [DW-1:0]              axi_rdata,
    input  logic                       axi_rlast,
    input  logic                       axi_rvalid,
    output logic                       axi_rready,
    output logic [DW-1:0]              out_data,
    output logic                       out_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic                       err_clr,
    output logic                       busy,
    output logic                       len_err,
    output logic                       ar_ovf,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [LW:0]     r_exp;
    logic [LW:0]     r_cnt;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_level;
    logic [DW:0]     r_mem [DEPTH];
    logic            r_len_err;
    logic            r_ar_ovf;

    logic            w_ar_hs;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [LW:0]     w_cnt_inc;
    logic            w_cnt_hit;
    logic            w_last_eff;
    logic            w_capture;
    logic [DW:0]     w_head;

    assign w_ar_hs    = axi_arvalid & axi_arready;
    assign w_full     = (r_level == (AW+1)'(DEPTH));
    assign w_empty    = (r_level == '0);
    assign w_cnt_inc  = r_cnt + {{LW{1'b0}}, 1'b1};
    assign w_cnt_hit  = (w_cnt_inc == r_exp);
    assign w_last_eff = axi_rlast | w_cnt_hit;
    assign w_push     = axi_rvalid & axi_rready;
    assign w_pop      = out_valid & out_ready;
    assign w_head     = r_mem[r_rd_ptr];

    // axi_rready is a function of state and occupancy only, never of axi_rvalid.
    assign axi_rready = (r_state == RECV) & ~w_full;
    assign out_valid  = ~w_empty;
    assign out_data   = w_empty ? '0 : w_head[DW-1:0];
    assign out_last   = w_empty ? 1'b0 : w_head[DW];
    assign busy       = (r_state == RECV);
    assign len_err    = r_len_err;
    assign ar_ovf     = r_ar_ovf;
    assign level      = r_level;

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ar_hs) begin
                    w_capture    = 1'b1;
                    w_state_next = RECV;
                end
            end
            RECV: begin
                if (w_push && w_last_eff) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_exp   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_exp <= {1'b0, axi_arlen} + {{LW{1'b0}}, 1'b1};
                r_cnt <= '0;
            end else if (w_push) begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_len_err <= 1'b0;
            r_ar_ovf  <= 1'b0;
        end else begin
            // A set event in the same cycle as err_clr takes priority.
            if (w_push && (axi_rlast ^ w_cnt_hit)) begin
                r_len_err <= 1'b1;
            end else if (err_clr) begin
                r_len_err <= 1'b0;
            end
            if (w_ar_hs && (r_state == RECV)) begin
                r_ar_ovf <= 1'b1;
            end else if (err_clr) begin
                r_ar_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // NOTE: storage is not reset; outputs are masked while empty so stale contents never escape.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_last_eff, axi_rdata};
        end
    end

endmodule

// File: tb/tb_axi_read_burst_collector.sv
// Directed bench for axi_read_burst_collector: drivers push expected beats into
// a scoreboard queue, a negedge monitor pops and compares on each output transfer.
module tb_axi_read_burst_collector;

    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int LW    = 8;

    logic            clk = 1'b0;
    logic            resetn;
    logic            axi_arvalid;
    logic            axi_arready;
    logic [LW-1:0]   axi_arlen;
    logic [DW-1:0]   axi_rdata;
    logic            axi_rlast;
    logic            axi_rvalid;
    logic            axi_rready;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            out_valid;
    logic            out_ready;
    logic            err_clr;
    logic            busy;
    logic            len_err;
    logic            ar_ovf;
    logic [2:0]      level;

    int n_checks = 0;
    int n_pass   = 0;
    logic [DW:0] sb_q[$];

    axi_read_burst_collector #(.DW(DW), .DEPTH(DEPTH), .LW(LW)) dut (
        .clk(clk), .resetn(resetn),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arlen(axi_arlen),
        .axi_rdata(axi_rdata), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .err_clr(err_clr),
        .busy(busy), .len_err(len_err), .ar_ovf(ar_ovf), .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every transfer on the output side must match the queue head.
    always @(negedge clk) begin
        if (resetn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_beat", {out_last, out_data}, '0);
            end else begin
                check("out_beat", {out_last, out_data}, sb_q.pop_front());
            end
        end
    end

    task automatic ar(input logic [LW-1:0] len);
        axi_arvalid = 1'b1;
        axi_arready = 1'b1;
        axi_arlen   = len;
        @(posedge clk); #1;
        axi_arvalid = 1'b0;
        axi_arready = 1'b0;
    endtask

    // Drive one R beat and wait (bounded) for its handshake; push expectation if asked.
    task automatic rbeat(input logic [DW-1:0] data, input logic last,
                         input logic exp_last, input logic expect_out);
        bit done = 0;
        axi_rvalid = 1'b1;
        axi_rdata  = data;
        axi_rlast  = last;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (axi_rready) done = 1;
        end
        if (!done) begin
            check("rready_timeout", 1'b0, 1'b1);
        end else begin
            if (expect_out) sb_q.push_back({exp_last, data});
            @(posedge clk); #1;
        end
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
        check(name, sb_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
    endtask

    initial begin
        bit hs;
        resetn = 1'b0; axi_arvalid = 0; axi_arready = 0; axi_arlen = '0;
        axi_rdata = '0; axi_rlast = 0; axi_rvalid = 0; out_ready = 0; err_clr = 0;
        #22;
        check("rst_outputs", {axi_rready, out_valid, out_last, busy, len_err, ar_ovf, level},
              '0);
        check("rst_data", out_data, '0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Normal burst.
        out_ready = 1'b1;
        ar(8'd3);
        check("normal_busy", busy, 1'b1);
        rbeat(64'h11, 0, 0, 1);
        rbeat(64'h22, 0, 0, 1);
        rbeat(64'h33, 0, 0, 1);
        rbeat(64'h44, 1, 1, 1);
        check("normal_busy_drop", busy, 1'b0);
        check("normal_len_err", len_err, 1'b0);
        drain("normal_drain");

        // Backpressure: FIFO fills, then drains.
        out_ready = 1'b0;
        ar(8'd7);
        for (int i = 1; i <= 4; i++) rbeat(64'(i * 16 + 1), 0, 0, 1);
        @(negedge clk);
        check("bp_rready_low", axi_rready, 1'b0);
        check("bp_level_full", level, 3'd4);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 5; i <= 8; i++) rbeat(64'(i * 16 + 1), i == 8, i == 8, 1);
        drain("bp_drain");
        check("bp_level_empty", level, 3'd0);

        // Early RLAST.
        ar(8'd3);
        rbeat(64'hA1, 0, 0, 1);
        rbeat(64'hA2, 1, 1, 1);
        check("early_len_err", len_err, 1'b1);
        check("early_idle", busy, 1'b0);
        pulse_clr();
        check("early_clr", len_err, 1'b0);
        drain("early_drain");

        // Missing RLAST at maximum length.
        ar(8'd255);
        for (int i = 0; i < 255; i++) rbeat(64'(32'hC000 + i), 0, 0, 1);
        check("max_busy_255", busy, 1'b1);
        check("max_no_err_255", len_err, 1'b0);
        rbeat(64'hC0FF, 0, 1, 1);
        check("max_len_err", len_err, 1'b1);
        check("max_idle", busy, 1'b0);
        pulse_clr();
        drain("max_drain");

        // AR during RECV, then AR on the same edge the burst ends.
        ar(8'd1);
        rbeat(64'hB1, 0, 0, 1);
        ar(8'd5);
        check("ovf_set", ar_ovf, 1'b1);
        check("ovf_still_busy", busy, 1'b1);
        rbeat(64'hB2, 1, 1, 1);
        check("ovf_burst_done", busy, 1'b0);
        check("ovf_no_len_err", len_err, 1'b0);
        pulse_clr();
        check("ovf_clr", ar_ovf, 1'b0);
        ar(8'd0);
        axi_arvalid = 1; axi_arready = 1; axi_arlen = 8'd2;
        axi_rvalid = 1; axi_rdata = 64'hD1; axi_rlast = 1;
        @(negedge clk);
        hs = axi_rready;
        check("same_edge_rready", hs, 1'b1);
        if (hs) sb_q.push_back({1'b1, 64'hD1});
        @(posedge clk); #1;
        axi_arvalid = 0; axi_arready = 0; axi_rvalid = 0; axi_rlast = 0;
        check("same_edge_ovf", ar_ovf, 1'b1);
        check("same_edge_idle", busy, 1'b0);
        pulse_clr();
        drain("same_edge_drain");

        // Stray R beat in IDLE.
        axi_rvalid = 1; axi_rdata = 64'hEE;
        repeat (3) @(negedge clk);
        check("stray_rready", axi_rready, 1'b0);
        check("stray_level", level, 3'd0);
        @(posedge clk); #1;
        axi_rvalid = 0;

        // Reset mid-burst.
        out_ready = 1'b0;
        ar(8'd3);
        rbeat(64'hF1, 0, 0, 0);
        rbeat(64'hF2, 0, 0, 0);
        check("pre_rst_level", level, 3'd2);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_outputs", {axi_rready, out_valid, out_last, busy, len_err, ar_ovf, level},
              '0);
        check("mid_rst_data", out_data, '0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        check("post_rst_empty", out_valid, 1'b0);
        out_ready = 1'b1;
        ar(8'd0);
        rbeat(64'h5A, 1, 1, 1);
        check("post_rst_idle", busy, 1'b0);
        check("post_rst_len_err", len_err, 1'b0);
        drain("post_rst_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
